// File: rtl/vip_pkg.sv
// Shared types and constants for the VIP memory subsystem.
// Owner encoding tracks which port a pending RAM response belongs to.
package vip_pkg;

    localparam int VIP_ADDR_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA
    } mem_owner_e;

    function automatic logic in_window(
        input logic [VIP_ADDR_W-1:0] addr,
        input logic [VIP_ADDR_W-1:0] base,
        input logic [VIP_ADDR_W-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/vip_mem_arb_prio.sv
// Fetch-priority arbiter with a starvation counter that
// hands data one grant after STARVE_MAX consecutive fetch wins.
module vip_mem_arb_prio
    import vip_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_req,
    input  logic       data_req,
    output mem_owner_e winner
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          starved;

    assign starved = data_req && (cnt_q == CNT_MAX);

    always_comb begin
        winner = OWN_NONE;
        if (rst_n) begin
            if (instr_req && !starved) begin
                winner = OWN_INSTR;
            end else if (data_req) begin
                winner = OWN_DATA;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!data_req || winner == OWN_DATA) begin
            cnt_d = '0;
        end else if (winner == OWN_INSTR && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vip_mem_arbiter.sv
// Two-port (fetch/LSU) to single-port RAM arbiter with window decode
// and a one-deep response tracker routing rvalid back to its owner.
module vip_mem_arbiter
    import vip_pkg::*;
#(
    parameter logic [31:0] MEM_START  = 32'h0000_0000,
    parameter int          MEM_SIZE   = 64 * 1024,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [VIP_ADDR_W-1:0] WIN_MASK =
        ~(VIP_ADDR_W'(MEM_SIZE) - VIP_ADDR_W'(1));

    mem_owner_e winner;
    mem_owner_e owner_q;
    logic       err_q;

    logic [31:0] win_addr;
    logic        in_win;
    logic        granted;
    logic        hit;
    logic        data_hit;
    logic [31:0] rsp_data;

    vip_mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .instr_req(instr_req_i),
        .data_req (data_req_i),
        .winner   (winner)
    );

    assign win_addr = (winner == OWN_DATA) ? data_addr_i : instr_addr_i;
    assign in_win   = in_window(win_addr, MEM_START, WIN_MASK);
    assign granted  = (winner != OWN_NONE);
    assign hit      = granted && in_win;
    assign data_hit = hit && (winner == OWN_DATA);

    assign instr_gnt_o = (winner == OWN_INSTR);
    assign data_gnt_o  = (winner == OWN_DATA);

    // Fetches never write, so the write side is driven by data only.
    assign mem_req_o   = hit;
    assign mem_we_o    = data_hit && data_we_i;
    assign mem_be_o    = data_hit ? data_be_i : 4'b0000;
    assign mem_addr_o  = hit ? win_addr : 32'h0;
    assign mem_wdata_o = data_hit ? data_wdata_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= winner;
            err_q   <= granted && !in_win;
        end
    end

    assign rsp_data = err_q ? 32'h0 : mem_rdata_i;

    assign instr_rvalid_o = (owner_q == OWN_INSTR);
    assign instr_rdata_o  = instr_rvalid_o ? rsp_data : 32'h0;
    assign instr_err_o    = instr_rvalid_o && err_q;

    assign data_rvalid_o = (owner_q == OWN_DATA);
    assign data_rdata_o  = data_rvalid_o ? rsp_data : 32'h0;
    assign data_err_o    = data_rvalid_o && err_q;

    // RAM must answer exactly the in-window grants of the previous cycle.
    rsp_consistent: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i == ((owner_q != OWN_NONE) && !err_q)
    );

endmodule
